// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-port controller for the 32-entry general purpose register file.
// Two writeback requesters, the ALU (port 0) and the load/memory unit
// (port 1), share the register file's single write port. Ties between them
// are broken round-robin. A busy scoreboard records registers that have a
// write outstanding. Decode uses it to detect read-after-write hazards and
// to stall write-after-write issue.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   issue_valid/issue_rd  decode issues an instruction that writes issue_rd
//   issue_ready           combinational; low while issue_rd is still busy
//   wbN_valid/addr/data   writeback request from port N (0 = ALU, 1 = mem)
//   wbN_ready             combinational grant; transfer when valid && ready
//   rf_write_enable/addr/data  registered drive of the register file port
//   query_addrN           source registers being read by decode
//   query_busyN           combinational; queried register has a pending write
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic                 wb0_valid,
    input  logic [4:0]           wb0_addr,
    input  logic [WORD_SIZE-1:0] wb0_data,
    output logic                 wb0_ready,
    input  logic                 wb1_valid,
    input  logic [4:0]           wb1_addr,
    input  logic [WORD_SIZE-1:0] wb1_data,
    output logic                 wb1_ready,
    output logic                 rf_write_enable,
    output logic [4:0]           rf_write_addr,
    output logic [WORD_SIZE-1:0] rf_write_data,
    input  logic [4:0]           query_addr1,
    input  logic [4:0]           query_addr2,
    output logic                 query_busy1,
    output logic                 query_busy2
);

    // Bit 0 is held at zero so x0 never reads as busy, so it can be
    // indexed directly by any 5-bit register number.
    logic [31:0]          busy;
    logic [31:0]          busy_next;
    logic                 last_grant;
    logic                 transfer;
    logic [4:0]           sel_addr;
    logic [WORD_SIZE-1:0] sel_data;
    logic                 issue_accept;

    // Round-robin grant: a lone requester always wins; on a tie the port
    // that did not win last time is granted.
    always_comb begin
        wb0_ready = wb0_valid && (!wb1_valid || last_grant);
        wb1_ready = wb1_valid && (!wb0_valid || !last_grant);
        transfer  = wb0_ready || wb1_ready;
        sel_addr  = wb1_ready ? wb1_addr : wb0_addr;
        sel_data  = wb1_ready ? wb1_data : wb0_data;
    end

    // Hazard outputs look only at the registered scoreboard. A clear that
    // happens on this edge does not release them early. This keeps the
    // dependent read behind the register file commit.
    always_comb begin
        issue_ready  = !busy[issue_rd];
        issue_accept = issue_valid && issue_ready;
        query_busy1  = busy[query_addr1];
        query_busy2  = busy[query_addr2];
    end

    // Next scoreboard value. The clear is applied before the set, so a new
    // issue to the same register on the same edge leaves it busy.
    always_comb begin
        busy_next = busy;
        if (transfer) begin
            busy_next[sel_addr] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // State update. last_grant resets to 1 so port 0 wins the first tie.
    // A write to x0 is consumed but never enables the register file.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy            <= '0;
            last_grant      <= 1'b1;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            busy <= busy_next;
            if (transfer) begin
                last_grant      <= wb1_ready;
                rf_write_enable <= (sel_addr != 5'd0);
                rf_write_addr   <= sel_addr;
                rf_write_data   <= sel_data;
            end else begin
                rf_write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed testbench for regfile_wb_arbiter. A table of per-cycle input
// records carries hand-computed expectations. Combinational outputs are
// compared mid-cycle. The registered rf_write_* outputs are compared just
// after the following posedge. A hand-written sweep covers the post-reset
// state for every register number.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb0_valid;
    logic [4:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [4:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  query_addr1;
    logic [4:0]  query_addr2;
    logic        query_busy1;
    logic        query_busy2;

    int passCount = 0;
    int totalCount = 0;

    regfile_wb_arbiter #(.WORD_SIZE(32)) dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb0_valid(wb0_valid),
        .wb0_addr(wb0_addr),
        .wb0_data(wb0_data),
        .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid),
        .wb1_addr(wb1_addr),
        .wb1_data(wb1_data),
        .wb1_ready(wb1_ready),
        .rf_write_enable(rf_write_enable),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .query_addr1(query_addr1),
        .query_addr2(query_addr2),
        .query_busy1(query_busy1),
        .query_busy2(query_busy2)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [4:0]  ird;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        eIr;
        logic        eR0;
        logic        eR1;
        logic        eQb1;
        logic        eQb2;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic iv, input logic [4:0] ird,
        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic [4:0] q1, input logic [4:0] q2,
        input logic eIr, input logic eR0, input logic eR1,
        input logic eQb1, input logic eQb2,
        input logic eWe, input logic [4:0] eAddr, input logic [31:0] eData);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = ird;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.q1 = q1; v.q2 = q2;
        v.eIr = eIr; v.eR0 = eR0; v.eR1 = eR1;
        v.eQb1 = eQb1; v.eQb2 = eQb2;
        v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset       = v.rst;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        wb0_valid   = v.v0;
        wb0_addr    = v.a0;
        wb0_data    = v.d0;
        wb1_valid   = v.v1;
        wb1_addr    = v.a1;
        wb1_data    = v.d1;
        query_addr1 = v.q1;
        query_addr2 = v.q2;
    endtask

    task automatic idleInputs();
        reset = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
        wb0_valid = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
        wb1_valid = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
        query_addr1 = 5'd0; query_addr2 = 5'd0;
    endtask

    initial begin
        //        rst iv ird  v0 a0  d0            v1 a1  d1            q1  q2   Ir R0 R1 Qb1 Qb2 We Addr  Data
        // Issue rd5, then writeback of rd5 from port 0.
        vecs[0]  = mk(0, 0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        vecs[1]  = mk(0, 1, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        vecs[2]  = mk(0, 0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd5, 5'd0, 1, 0, 0, 1, 0, 0, 5'd0, 32'h0);
        vecs[3]  = mk(0, 0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        5'd5, 5'd0, 1, 1, 0, 1, 0, 1, 5'd5, 32'hDEADBEEF);
        vecs[4]  = mk(0, 0, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 5'd5, 32'hDEADBEEF);
        // Reset, then four cycles of contention: 0,1,0,1.
        vecs[5]  = mk(1, 0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        vecs[6]  = mk(0, 0, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 5'd1, 5'd2, 1, 1, 0, 0, 0, 1, 5'd1, 32'h11111111);
        vecs[7]  = mk(0, 0, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 5'd1, 5'd2, 1, 0, 1, 0, 0, 1, 5'd2, 32'h22222222);
        vecs[8]  = mk(0, 0, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 5'd1, 5'd2, 1, 1, 0, 0, 0, 1, 5'd1, 32'h11111111);
        vecs[9]  = mk(0, 0, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 5'd1, 5'd2, 1, 0, 1, 0, 0, 1, 5'd2, 32'h22222222);
        // Port 1 alone writes x0: consumed, no enable, data still captured.
        vecs[10] = mk(0, 0, 5'd0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h00001234, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 5'd0, 32'h00001234);
        // busy[7] set; reissue of rd7 stalls while port 1 clears it.
        vecs[11] = mk(0, 1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd7, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h00001234);
        vecs[12] = mk(0, 1, 5'd7, 0, 5'd0, 32'h0,        1, 5'd7, 32'h77777777, 5'd7, 5'd0, 0, 0, 1, 1, 0, 1, 5'd7, 32'h77777777);
        vecs[13] = mk(0, 1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd7, 5'd0, 1, 0, 0, 0, 0, 0, 5'd7, 32'h77777777);
        vecs[14] = mk(0, 0, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd7, 5'd0, 0, 0, 0, 1, 0, 0, 5'd7, 32'h77777777);
        // Same-edge set and clear of rd3 (not busy): set wins.
        vecs[15] = mk(0, 1, 5'd9, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd9, 5'd3, 1, 0, 0, 0, 0, 0, 5'd7, 32'h77777777);
        vecs[16] = mk(0, 1, 5'd3, 1, 5'd3, 32'h33333333, 0, 5'd0, 32'h0,        5'd9, 5'd3, 1, 1, 0, 1, 0, 1, 5'd3, 32'h33333333);
        vecs[17] = mk(0, 0, 5'd3, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd3, 5'd9, 0, 0, 0, 1, 1, 0, 5'd3, 32'h33333333);
        // Reset mid-stream under contention; port 0 first afterwards.
        vecs[18] = mk(1, 0, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 5'd3, 5'd9, 1, 0, 1, 1, 1, 0, 5'd0, 32'h0);
        vecs[19] = mk(0, 0, 5'd0, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 5'd3, 5'd9, 1, 1, 0, 0, 0, 1, 5'd1, 32'h11111111);
        vecs[20] = mk(0, 0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd3, 5'd9, 1, 0, 0, 0, 0, 0, 5'd1, 32'h11111111);

        idleInputs();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Post-reset state: registered outputs cleared.
        checkOutput("reset_we", -1, 32'(rf_write_enable), 32'd0);
        checkOutput("reset_addr", -1, 32'(rf_write_addr), 32'd0);
        checkOutput("reset_data", -1, rf_write_data, 32'd0);

        // Every register is free: issue_ready high, queries low.
        for (int r = 0; r < 32; r++) begin
            issue_rd    = 5'(r);
            query_addr1 = 5'(r);
            query_addr2 = 5'(31 - r);
            #1;
            checkOutput("reset_issue_ready", r, 32'(issue_ready), 32'd1);
            checkOutput("reset_qbusy1", r, 32'(query_busy1), 32'd0);
            checkOutput("reset_qbusy2", r, 32'(query_busy2), 32'd0);
        end
        idleInputs();
        @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput("issue_ready", i, 32'(issue_ready), 32'(vecs[i].eIr));
            checkOutput("wb0_ready", i, 32'(wb0_ready), 32'(vecs[i].eR0));
            checkOutput("wb1_ready", i, 32'(wb1_ready), 32'(vecs[i].eR1));
            checkOutput("query_busy1", i, 32'(query_busy1), 32'(vecs[i].eQb1));
            checkOutput("query_busy2", i, 32'(query_busy2), 32'(vecs[i].eQb2));
            @(posedge clock);
            #1;
            checkOutput("rf_write_enable", i, 32'(rf_write_enable), 32'(vecs[i].eWe));
            checkOutput("rf_write_addr", i, 32'(rf_write_addr), 32'(vecs[i].eAddr));
            checkOutput("rf_write_data", i, rf_write_data, vecs[i].eData);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
